wb_scoreboard: RTL and testbench

Writeback sequencer and hazard scoreboard for the 4-lane VLIW core. It sits between issue/execute and the 64-entry integer/float register file, whose write ports it drives. Lanes 1–2 are fixed-latency ALU lanes. Lanes 3–4 are variable-latency memory lanes that return load data in order per lane. It tracks a busy bit per register and raises `stall` on RAW and WAW hazards and on load-queue overflow.

---
 rtl/wb_scoreboard_if.sv | 41 ++++
 rtl/wb_scoreboard.sv | 201 ++++++++++++++++++++
 tb/tb_wb_scoreboard.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_scoreboard_if.sv
// wb_scoreboard_if: issue, execute, memory-return and writeback signals of the
// 4-lane writeback sequencer, bundled for connection to wb_scoreboard.
interface wb_scoreboard_if;
    logic        issue_en;
    logic [5:0]  rs11, rs12, rs21, rs22, rs31, rs32, rs41, rs42;
    logic [6:0]  iss_rd1, iss_rd2, iss_rd3, iss_rd4;
    logic [31:0] ex_res1, ex_res2;
    logic        mem_valid3, mem_valid4;
    logic [31:0] mem_data3, mem_data4;
    logic        stall;
    logic [6:0]  wb_rd1, wb_rd2, wb_rd3, wb_rd4;
    logic [31:0] wb_res1, wb_res2, wb_memdata3, wb_memdata4;
    logic        lq_err;
    logic [31:0] stall_cycles;

    // Scoreboard side
    modport slave (
        input  issue_en,
        input  rs11, rs12, rs21, rs22, rs31, rs32, rs41, rs42,
        input  iss_rd1, iss_rd2, iss_rd3, iss_rd4,
        input  ex_res1, ex_res2,
        input  mem_valid3, mem_valid4, mem_data3, mem_data4,
        output stall,
        output wb_rd1, wb_rd2, wb_rd3, wb_rd4,
        output wb_res1, wb_res2, wb_memdata3, wb_memdata4,
        output lq_err, stall_cycles
    );

    // Issue/execute/memory side
    modport master (
        output issue_en,
        output rs11, rs12, rs21, rs22, rs31, rs32, rs41, rs42,
        output iss_rd1, iss_rd2, iss_rd3, iss_rd4,
        output ex_res1, ex_res2,
        output mem_valid3, mem_valid4, mem_data3, mem_data4,
        input  stall,
        input  wb_rd1, wb_rd2, wb_rd3, wb_rd4,
        input  wb_res1, wb_res2, wb_memdata3, wb_memdata4,
        input  lq_err, stall_cycles
    );
endinterface

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: writeback sequencer and hazard scoreboard for the 4-lane VLIW
// core. Lanes 1-2 are fixed one-stage ALU lanes, lanes 3-4 are in-order load
// lanes each with a pending-destination FIFO. A busy bit per register drives
// RAW/WAW stalls; a full load queue also stalls.
// Optional: define WB_STALL_CNT_EN to build the stalled-issue-cycle counter;
// otherwise stall_cycles is tied to 0.
module wb_scoreboard #(
    parameter int unsigned LQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    wb_scoreboard_if.slave  bus
);
    localparam int unsigned AW = $clog2(LQ_DEPTH);

    logic [5:0]  w_rs [8];
    logic [6:0]  w_rd [4];
    logic [3:0]  w_dst_en;
    logic [31:0] w_ex [2];
    logic [1:0]  w_mv;
    logic [31:0] w_md [2];

    logic [63:0] r_busy;
    logic [63:0] w_busy_nxt;
    logic        w_haz;
    logic        w_stall;
    logic        w_acc;

    logic [6:0]  r_pipe [2];
    logic [6:0]  r_alu_rd [2];
    logic [31:0] r_alu_res [2];

    logic [5:0]  r_lq [2][LQ_DEPTH];
    logic [AW:0] r_wp [2];
    logic [AW:0] r_rp [2];
    logic [1:0]  w_full;
    logic [1:0]  w_empty;
    logic [1:0]  w_push;
    logic [1:0]  w_pop;
    logic [6:0]  r_ld_rd [2];
    logic [31:0] r_ld_data [2];
    logic        r_lq_err;

    assign w_rs[0] = bus.rs11;
    assign w_rs[1] = bus.rs12;
    assign w_rs[2] = bus.rs21;
    assign w_rs[3] = bus.rs22;
    assign w_rs[4] = bus.rs31;
    assign w_rs[5] = bus.rs32;
    assign w_rs[6] = bus.rs41;
    assign w_rs[7] = bus.rs42;
    assign w_rd[0] = bus.iss_rd1;
    assign w_rd[1] = bus.iss_rd2;
    assign w_rd[2] = bus.iss_rd3;
    assign w_rd[3] = bus.iss_rd4;
    assign w_ex[0] = bus.ex_res1;
    assign w_ex[1] = bus.ex_res2;
    assign w_mv    = {bus.mem_valid4, bus.mem_valid3};
    assign w_md[0] = bus.mem_data3;
    assign w_md[1] = bus.mem_data4;

    // Destination enables: register 0 is never a real destination
    always_comb begin
        w_dst_en = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_dst_en[i] = w_rd[i][6] && (w_rd[i][5:0] != 6'd0);
        end
    end

    // RAW on any nonzero source, WAW on any enabled destination
    always_comb begin
        w_haz = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (w_rs[i] != 6'd0 && r_busy[w_rs[i]]) w_haz = 1'b1;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_dst_en[i] && r_busy[w_rd[i][5:0]]) w_haz = 1'b1;
        end
    end

    // Load-queue occupancy; full/empty from the extra wrap bit
    always_comb begin
        w_full  = '0;
        w_empty = '0;
        w_push  = '0;
        w_pop   = '0;
        for (int unsigned l = 0; l < 2; l++) begin
            w_full[l]  = (r_wp[l][AW] != r_rp[l][AW]) &&
                         (r_wp[l][AW-1:0] == r_rp[l][AW-1:0]);
            w_empty[l] = (r_wp[l] == r_rp[l]);
            w_push[l]  = w_acc && w_dst_en[l+2];
            w_pop[l]   = w_mv[l] && !w_empty[l];
        end
    end

    // Queue-full stall looks only at the start-of-cycle occupancy, so a
    // same-cycle pop never frees a slot for the presented bundle.
    assign w_stall = rst && bus.issue_en &&
                     (w_haz || (w_dst_en[2] && w_full[0]) || (w_dst_en[3] && w_full[1]));
    assign w_acc   = bus.issue_en && !w_stall;

    // Busy update: clear on presented writeback, then set on accept (set wins)
    always_comb begin
        w_busy_nxt = r_busy;
        for (int unsigned l = 0; l < 2; l++) begin
            if (r_alu_rd[l][6]) w_busy_nxt[r_alu_rd[l][5:0]] = 1'b0;
            if (r_ld_rd[l][6])  w_busy_nxt[r_ld_rd[l][5:0]]  = 1'b0;
        end
        if (w_acc) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_dst_en[i]) w_busy_nxt[w_rd[i][5:0]] = 1'b1;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Busy-bit register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_busy <= '0;
        else      r_busy <= w_busy_nxt;
    end

    // ALU lanes: destination piped one stage, then written with ex_res
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned l = 0; l < 2; l++) begin
                r_pipe[l]    <= '0;
                r_alu_rd[l]  <= '0;
                r_alu_res[l] <= '0;
            end
        end else begin
            for (int unsigned l = 0; l < 2; l++) begin
                r_pipe[l] <= (w_acc && w_dst_en[l]) ? w_rd[l] : 7'd0;
                if (r_pipe[l][6]) begin
                    r_alu_rd[l]  <= r_pipe[l];
                    r_alu_res[l] <= w_ex[l];
                end else begin
                    r_alu_rd[l][6] <= 1'b0;
                end
            end
        end
    end

    // Load-queue storage
    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < 2; l++) begin
            if (w_push[l]) r_lq[l][r_wp[l][AW-1:0]] <= w_rd[l+2][5:0];
        end
    end

    // Load-queue pointers, load writeback and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned l = 0; l < 2; l++) begin
                r_wp[l]      <= '0;
                r_rp[l]      <= '0;
                r_ld_rd[l]   <= '0;
                r_ld_data[l] <= '0;
            end
            r_lq_err <= 1'b0;
        end else begin
            for (int unsigned l = 0; l < 2; l++) begin
                if (w_push[l]) r_wp[l] <= r_wp[l] + 1'b1;
                if (w_pop[l]) begin
                    r_rp[l]      <= r_rp[l] + 1'b1;
                    r_ld_rd[l]   <= {1'b1, r_lq[l][r_rp[l][AW-1:0]]};
                    r_ld_data[l] <= w_md[l];
                end else begin
                    r_ld_rd[l][6] <= 1'b0;
                end
                if ((w_mv[l] && w_empty[l]) || (w_push[l] && w_full[l])) r_lq_err <= 1'b1;
            end
        end
    end

`ifdef WB_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Stalled-issue-cycle counter, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       r_stall_cnt <= '0;
        else if (bus.issue_en && w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign bus.stall_cycles = r_stall_cnt;
`else
    assign bus.stall_cycles = '0;
`endif

    assign bus.stall       = w_stall;
    assign bus.wb_rd1      = r_alu_rd[0];
    assign bus.wb_rd2      = r_alu_rd[1];
    assign bus.wb_rd3      = r_ld_rd[0];
    assign bus.wb_rd4      = r_ld_rd[1];
    assign bus.wb_res1     = r_alu_res[0];
    assign bus.wb_res2     = r_alu_res[1];
    assign bus.wb_memdata3 = r_ld_data[0];
    assign bus.wb_memdata4 = r_ld_data[1];
    assign bus.lq_err      = r_lq_err;

endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: directed stimulus for wb_scoreboard; expected register-file
// writes are queued at issue time and matched by an independent writeback
// monitor, while stall/status expectations are checked inline.
module tb_wb_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    wb_scoreboard_if bus();

    wb_scoreboard #(.LQ_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int unsigned lane;
        logic [5:0]  rg;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input int unsigned lane, input logic [5:0] rg, input logic [31:0] d);
        wb_exp_t e;
        e.lane = lane;
        e.rg   = rg;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_in();
        bus.issue_en   = 1'b0;
        bus.rs11 = '0; bus.rs12 = '0; bus.rs21 = '0; bus.rs22 = '0;
        bus.rs31 = '0; bus.rs32 = '0; bus.rs41 = '0; bus.rs42 = '0;
        bus.iss_rd1 = '0; bus.iss_rd2 = '0; bus.iss_rd3 = '0; bus.iss_rd4 = '0;
        bus.ex_res1 = '0; bus.ex_res2 = '0;
        bus.mem_valid3 = 1'b0; bus.mem_valid4 = 1'b0;
        bus.mem_data3  = '0;   bus.mem_data4  = '0;
    endtask

    // Writeback monitor: every presented write must match the queue head
    initial begin
        logic [6:0]  rd;
        logic [31:0] d;
        wb_exp_t     e;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int unsigned l = 1; l <= 4; l++) begin
                    case (l)
                        1: begin rd = bus.wb_rd1; d = bus.wb_res1;     end
                        2: begin rd = bus.wb_rd2; d = bus.wb_res2;     end
                        3: begin rd = bus.wb_rd3; d = bus.wb_memdata3; end
                        default: begin rd = bus.wb_rd4; d = bus.wb_memdata4; end
                    endcase
                    if (rd[6]) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_wb lane%0d: got reg %0d data 0x%08h, expected no write",
                                     l, rd[5:0], d);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("wb_lane_reg(lane<<8|reg) lane%0d", l),
                                (32'(l) << 8) | 32'(rd[5:0]), (32'(e.lane) << 8) | 32'(e.rg));
                            chk($sformatf("wb_data lane%0d", l), d, e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        clear_in();
        // Reset state (with a bundle presented during reset)
        bus.issue_en = 1'b1;
        bus.iss_rd3  = 7'h49;
        #2;
        chk("reset_stall", 32'(bus.stall), 32'd0);
        chk("reset_wb_rd", {4'd0, bus.wb_rd1, bus.wb_rd2, bus.wb_rd3, bus.wb_rd4}, 32'd0);
        chk("reset_wb_data_or", bus.wb_res1 | bus.wb_res2 | bus.wb_memdata3 | bus.wb_memdata4, 32'd0);
        chk("reset_lq_err", 32'(bus.lq_err), 32'd0);
        chk("reset_stall_cycles", bus.stall_cycles, 32'd0);
        clear_in();
        #10;
        rst = 1'b1;
        step();
        step();

        // Back-to-back RAW on ALU lane 1
        bus.issue_en = 1'b1;
        bus.iss_rd1  = 7'h45;
        settle();
        chk("raw_A_accept", 32'(bus.stall), 32'd0);
        expect_wb(1, 6'd5, 32'h1234);
        step();
        bus.iss_rd1 = '0;
        bus.rs11    = 6'd5;
        bus.ex_res1 = 32'h1234;
        settle();
        chk("raw_stall_T1", 32'(bus.stall), 32'd1);
        step();
        bus.ex_res1 = '0;
        settle();
        chk("raw_stall_T2", 32'(bus.stall), 32'd1);
        chk("raw_wb_rd1_T2", 32'(bus.wb_rd1), 32'h45);
        chk("raw_wb_res1_T2", bus.wb_res1, 32'h1234);
        step();
        chk("raw_release_T3", 32'(bus.stall), 32'd0);
        step();
        clear_in();
        step();

        // Load latency on lane 3
        bus.issue_en = 1'b1;
        bus.iss_rd3  = 7'h68;
        settle();
        chk("ld_accept", 32'(bus.stall), 32'd0);
        expect_wb(3, 6'd40, 32'hDEADBEEF);
        step();
        bus.iss_rd3 = '0;
        bus.rs11    = 6'd40;
        for (int i = 1; i <= 4; i++) begin
            settle();
            chk($sformatf("ld_reader_stall_T%0d", i), 32'(bus.stall), 32'd1);
            step();
        end
        bus.mem_valid3 = 1'b1;
        bus.mem_data3  = 32'hDEADBEEF;
        settle();
        chk("ld_reader_stall_M", 32'(bus.stall), 32'd1);
        step();
        bus.mem_valid3 = 1'b0;
        bus.mem_data3  = '0;
        settle();
        chk("ld_reader_stall_M1", 32'(bus.stall), 32'd1);
        chk("ld_wb_rd3", 32'(bus.wb_rd3), 32'h68);
        chk("ld_wb_memdata3", bus.wb_memdata3, 32'hDEADBEEF);
        step();
        chk("ld_reader_release_M2", 32'(bus.stall), 32'd0);
        step();
        clear_in();
        step();

        // Queue full on lane 3
        bus.issue_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.iss_rd3 = 7'h40 | 7'(10 + i);
            settle();
            chk($sformatf("lq_fill_accept_%0d", i), 32'(bus.stall), 32'd0);
            step();
        end
        bus.iss_rd3 = 7'h4E;
        settle();
        chk("lq_full_stall", 32'(bus.stall), 32'd1);
        step();
        chk("lq_full_stall_hold", 32'(bus.stall), 32'd1);
        bus.mem_valid3 = 1'b1;
        bus.mem_data3  = 32'hA0A0A0A0;
        expect_wb(3, 6'd10, 32'hA0A0A0A0);
        settle();
        chk("lq_pop_no_free", 32'(bus.stall), 32'd1);
        step();
        bus.mem_valid3 = 1'b0;
        settle();
        chk("lq_fifth_accept", 32'(bus.stall), 32'd0);
        chk("lq_wb_rd3_r10", 32'(bus.wb_rd3), 32'h4A);
        step();
        clear_in();
        for (int k = 0; k < 4; k++) begin
            bus.mem_valid3 = 1'b1;
            bus.mem_data3  = 32'h100 + 32'(k);
            expect_wb(3, 6'(11 + k), 32'h100 + 32'(k));
            step();
        end
        clear_in();
        step();
        step();

        // WAW against a pending load, and r0 destination
        bus.issue_en = 1'b1;
        bus.iss_rd4  = 7'h47;
        settle();
        chk("waw_load_accept", 32'(bus.stall), 32'd0);
        step();
        bus.iss_rd4 = '0;
        bus.iss_rd2 = 7'h47;
        settle();
        chk("waw_stall", 32'(bus.stall), 32'd1);
        bus.iss_rd2 = '0;
        bus.iss_rd1 = 7'h40;
        bus.rs11    = 6'd0;
        settle();
        chk("r0_no_stall", 32'(bus.stall), 32'd0);
        step();
        clear_in();
        bus.ex_res1 = 32'hBAD0BAD0;
        step();
        bus.ex_res1 = '0;
        chk("r0_no_write", 32'(bus.wb_rd1[6]), 32'd0);
        bus.mem_valid4 = 1'b1;
        bus.mem_data4  = 32'h77;
        expect_wb(4, 6'd7, 32'h77);
        step();
        bus.mem_valid4 = 1'b0;
        chk("waw_wb_rd4", 32'(bus.wb_rd4), 32'h47);
        step();
        bus.issue_en = 1'b1;
        bus.iss_rd2  = 7'h47;
        settle();
        chk("waw_release", 32'(bus.stall), 32'd0);
        expect_wb(2, 6'd7, 32'h99);
        step();
        clear_in();
        bus.ex_res2 = 32'h99;
        step();
        bus.ex_res2 = '0;
        chk("alu2_wb_rd2", 32'(bus.wb_rd2), 32'h47);
        chk("alu2_wb_res2", bus.wb_res2, 32'h99);
        step();

        // Spurious return on lane 4
        bus.mem_valid4 = 1'b1;
        bus.mem_data4  = 32'h5555;
        step();
        bus.mem_valid4 = 1'b0;
        chk("spurious_lq_err", 32'(bus.lq_err), 32'd1);
        chk("spurious_no_write", 32'(bus.wb_rd4[6]), 32'd0);
        step();

        // Asynchronous reset mid-cycle with work in flight
        bus.issue_en = 1'b1;
        bus.iss_rd1  = 7'h55;
        bus.iss_rd3  = 7'h54;
        settle();
        chk("pre_reset_accept", 32'(bus.stall), 32'd0);
        step();
        clear_in();
        step();
        chk("pre_reset_wb_rd1", 32'(bus.wb_rd1), 32'h55);
        #1;
        rst = 1'b0;
        bus.issue_en = 1'b1;
        bus.rs11     = 6'd20;
        #1;
        chk("async_rst_wb_rd", {4'd0, bus.wb_rd1, bus.wb_rd2, bus.wb_rd3, bus.wb_rd4}, 32'd0);
        chk("async_rst_lq_err", 32'(bus.lq_err), 32'd0);
        chk("async_rst_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.rs11 = 6'd21;
        bus.rs12 = 6'd20;
        settle();
        chk("post_rst_busy_clear", 32'(bus.stall), 32'd0);
        step();
        clear_in();
        bus.mem_valid3 = 1'b1;
        bus.mem_data3  = 32'h3333;
        step();
        bus.mem_valid3 = 1'b0;
        chk("post_rst_discarded_lq_err", 32'(bus.lq_err), 32'd1);
        chk("post_rst_no_write", 32'(bus.wb_rd3[6]), 32'd0);
        step();

        // Stall counter: three stalled issue cycles since reset
        bus.issue_en = 1'b1;
        bus.iss_rd3  = 7'h5E;
        settle();
        chk("cnt_load_accept", 32'(bus.stall), 32'd0);
        step();
        bus.iss_rd3 = '0;
        bus.rs11    = 6'd30;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("cnt_stall_%0d", i), 32'(bus.stall), 32'd1);
            step();
        end
        bus.issue_en = 1'b0;
        bus.rs11     = '0;
        settle();
`ifdef WB_STALL_CNT_EN
        chk("stall_cycles", bus.stall_cycles, 32'd3);
`else
        chk("stall_cycles", bus.stall_cycles, 32'd0);
`endif
        bus.mem_valid3 = 1'b1;
        bus.mem_data3  = 32'h00C0FFEE;
        expect_wb(3, 6'd30, 32'h00C0FFEE);
        step();
        clear_in();
        step();
        step();
        step();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
